// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - byte-serial multi-byte add/subtract sequencer on a shared 8-bit adder
// full_adder_8 is the shared 8-bit ripple slice; add_seq_ctrl walks it LSB byte first.

module full_adder_8 (
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic       Cin,
   output logic [7:0] Sum,
   output logic       Cout
);
   logic c;

   always_comb begin
      c   = Cin;
      Sum = '0;
      for (int i = 0; i < 8; i++) begin
         Sum[i] = X[i] ^ Y[i] ^ c;
         c      = (X[i] & Y[i]) | (c & (X[i] ^ Y[i]));
      end
      Cout = c;
   end
endmodule

module add_seq_ctrl #(
   parameter int BYTES = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Sub,
   input  logic [8*BYTES-1:0]   A,
   input  logic [8*BYTES-1:0]   B,
   output logic                 Busy,
   output logic                 Done,
   output logic [8*BYTES-1:0]   Result,
   output logic                 Cout,
   output logic                 Overflow
);
   localparam int W     = 8 * BYTES;
   localparam int IDX_W = $clog2(BYTES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     opa_q, opa_d;
   logic [W-1:0]     opb_q, opb_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     result_q, result_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [7:0]       fa_x, fa_y, fa_sum;
   logic             fa_cout;
   logic             last;

   assign fa_x = opa_q[{idx_q, 3'b000} +: 8];
   assign fa_y = opb_q[{idx_q, 3'b000} +: 8];
   assign last = (idx_q == IDX_W'(BYTES - 1));

   full_adder_8 u_adder (
      .Sum  (fa_sum),
      .Cout (fa_cout),
      .X    (fa_x),
      .Y    (fa_y),
      .Cin  (carry_q)
   );

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      result_d = result_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
               opa_d   = A;
               opb_d   = Sub ? ~B : B;
               carry_d = Sub;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[{idx_q, 3'b000} +: 8] = fa_sum;
            carry_d = fa_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (last) begin
               result_d = acc_d;
               cout_d   = fa_cout;
               ovf_d    = (opa_q[W-1] == opb_q[W-1]) && (fa_sum[7] != opa_q[W-1]);
               done_d   = 1'b1;
               busy_d   = 1'b0;
               idx_d    = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Result   = result_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - scoreboard bench for add_seq_ctrl at BYTES = 4, 2 and 16
// Index 0 is the 4-byte instance, 1 the 2-byte one, 2 the 16-byte one.

module tb_add_seq_ctrl;
   typedef struct {
      logic [127:0] res;
      logic         cout;
      logic         ovf;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_seen = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic start4, sub4, start2, sub2, start16, sub16;
   logic [31:0]  a4, b4, res4;
   logic [15:0]  a2, b2, res2;
   logic [127:0] a16, b16, res16;
   logic busy4, done4, cout4, ovf4;
   logic busy2, done2, cout2, ovf2;
   logic busy16, done16, cout16, ovf16;

   logic         busy_v [3];
   logic         done_v [3];
   logic         cout_v [3];
   logic         ovf_v  [3];
   logic [127:0] res_v  [3];

   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];
   int   run [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rst_seen <= rst;

   add_seq_ctrl #(.BYTES(4)) u4 (
      .Clk(clk), .Reset(rst), .Start(start4), .Sub(sub4), .A(a4), .B(b4),
      .Busy(busy4), .Done(done4), .Result(res4), .Cout(cout4), .Overflow(ovf4));
   add_seq_ctrl #(.BYTES(2)) u2 (
      .Clk(clk), .Reset(rst), .Start(start2), .Sub(sub2), .A(a2), .B(b2),
      .Busy(busy2), .Done(done2), .Result(res2), .Cout(cout2), .Overflow(ovf2));
   add_seq_ctrl #(.BYTES(16)) u16 (
      .Clk(clk), .Reset(rst), .Start(start16), .Sub(sub16), .A(a16), .B(b16),
      .Busy(busy16), .Done(done16), .Result(res16), .Cout(cout16), .Overflow(ovf16));

   always_comb begin
      busy_v[0] = busy4;  busy_v[1] = busy2;  busy_v[2] = busy16;
      done_v[0] = done4;  done_v[1] = done2;  done_v[2] = done16;
      cout_v[0] = cout4;  cout_v[1] = cout2;  cout_v[2] = cout16;
      ovf_v[0]  = ovf4;   ovf_v[1]  = ovf2;   ovf_v[2]  = ovf16;
      res_v[0]  = 128'(res4);
      res_v[1]  = 128'(res2);
      res_v[2]  = res16;
   end

   function automatic int nb(int g);
      return (g == 0) ? 4 : ((g == 1) ? 2 : 16);
   endfunction

   task automatic chk(string name, int g, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (BYTES=%0d) at cycle %0d: got %0h, expected %0h",
                  name, nb(g), cyc, act, exp);
      end
   endtask

   // Reference: plain wide arithmetic on unsigned values plus sign rules.
   function automatic exp_t model(int g, bit sb, logic [127:0] a, logic [127:0] b, int issue);
      exp_t         e;
      int           w;
      logic [128:0] m, aa, bb, r;
      bit           sa, sbv, sr;
      w  = 8 * nb(g);
      m  = (129'd1 << w) - 129'd1;
      aa = {1'b0, a} & m;
      bb = {1'b0, b} & m;
      if (sb) begin
         r      = (aa - bb) & m;
         e.cout = (aa >= bb);
      end else begin
         r      = aa + bb;
         e.cout = r[w];
         r      = r & m;
      end
      sa  = aa[w-1];
      sbv = bb[w-1];
      sr  = r[w-1];
      e.ovf = sb ? ((sa != sbv) && (sr != sa)) : ((sa == sbv) && (sr != sa));
      e.res = r[127:0];
      e.due = issue + nb(g);
      return e;
   endfunction

   function automatic void push_exp(int g, exp_t e);
      case (g)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic bit pop_exp(int g, output exp_t e);
      bit ok;
      ok = 1'b0;
      e  = '{res: '0, cout: 1'b0, ovf: 1'b0, due: 0};
      case (g)
         0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
      endcase
      return ok;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      for (int g = 0; g < 3; g++) begin
         if (rst_seen) begin
            run[g] = 0;
         end else begin
            if (busy_v[g]) run[g]++;
            else if (run[g] != 0) begin
               chk("busy_len", g, 128'(run[g]), 128'(nb(g)));
               run[g] = 0;
            end
            if (done_v[g] === 1'b1) begin
               chk("done_busy_excl", g, 128'(busy_v[g]), 128'd0);
               if (!pop_exp(g, e)) begin
                  chk("unexpected_done", g, 128'd1, 128'd0);
               end else begin
                  chk("result", g, res_v[g], e.res);
                  chk("cout", g, 128'(cout_v[g]), 128'(e.cout));
                  chk("overflow", g, 128'(ovf_v[g]), 128'(e.ovf));
                  chk("latency", g, 128'(cyc), 128'(e.due));
               end
            end
         end
      end
   end

   task automatic drive(int g, bit st, bit sb, logic [127:0] aa, logic [127:0] bb);
      case (g)
         0: begin start4 = st; sub4 = sb; a4 = aa[31:0]; b4 = bb[31:0]; end
         1: begin start2 = st; sub2 = sb; a2 = aa[15:0]; b2 = bb[15:0]; end
         default: begin start16 = st; sub16 = sb; a16 = aa; b16 = bb; end
      endcase
   endtask

   function automatic logic [127:0] rnd(int g);
      logic [127:0] v;
      int           w;
      w = 8 * nb(g);
      case ($urandom_range(0, 9))
         0: v = '1;
         1: v = '0;
         2: v = 128'd1 << (w - 1);
         3: v = (128'd1 << (w - 1)) - 128'd1;
         default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
      return v;
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic op(int g, bit sb, logic [127:0] aa, logic [127:0] bb);
      push_exp(g, model(g, sb, aa, bb, cyc + 1));
      drive(g, 1'b1, sb, aa, bb);
      @(posedge clk); #1;
      drive(g, 1'b0, ~sb, ~aa, ~bb);
   endtask

   // Wait so the next op lands gap cycles after the Done cycle; junk: 0 none, 1 random, 2 always.
   task automatic wait_done(int g, int gap, int junk);
      bit st;
      for (int j = 0; j < nb(g) + gap; j++) begin
         @(posedge clk); #1;
         st = (j < nb(g) - 1) && ((junk == 2) || (junk == 1 && $urandom_range(0, 1) == 1));
         drive(g, st, 1'($urandom()), rnd(g), rnd(g));
      end
   endtask

   task automatic regress(int g, int n);
      for (int i = 0; i < n; i++) begin
         op(g, 1'($urandom()), rnd(g), rnd(g));
         wait_done(g, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1);
      end
   endtask

   initial begin
      for (int g = 0; g < 3; g++) drive(g, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk("rst_busy", g, 128'(busy_v[g]), 128'd0);
         chk("rst_done", g, 128'(done_v[g]), 128'd0);
         chk("rst_result", g, res_v[g], 128'd0);
         chk("rst_cout", g, 128'(cout_v[g]), 128'd0);
         chk("rst_ovf", g, 128'(ovf_v[g]), 128'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      op(0, 1'b0, 128'h0000_00FF, 128'h0000_0001);  wait_done(0, 1, 0);
      op(0, 1'b0, 128'hFFFF_FFFF, 128'h0000_0001);  wait_done(0, 0, 0);
      op(0, 1'b0, 128'h7FFF_FFFF, 128'h0000_0001);  wait_done(0, 0, 0);
      op(0, 1'b1, 128'h0000_0005, 128'h0000_0007);  wait_done(0, 0, 0);
      op(0, 1'b1, 128'h8000_0000, 128'h0000_0001);  wait_done(0, 0, 0);

      op(0, 1'b0, 128'h1357_9BDF, 128'h2468_ACE0);  wait_done(0, 0, 2);
      op(0, 1'b0, 128'h0000_0001, 128'h0000_0002);  wait_done(0, 2, 0);

      op(0, 1'b0, 128'h0000_1000, 128'h0000_2000);
      @(posedge clk); #1;
      rst = 1'b1;
      q0.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", 0, 128'(busy_v[0]), 128'd0);
      chk("abort_result", 0, res_v[0], 128'd0);
      chk("abort_done", 0, 128'(done_v[0]), 128'd0);
      repeat (10) @(posedge clk);
      #1;
      op(0, 1'b0, 128'h1234_5678, 128'h1111_1111);  wait_done(0, 1, 0);

      fork
         regress(1, 1000);
         regress(2, 1000);
      join

      for (int i = 0; i < 200 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
      #1;
      chk("drain", 0, 128'(q0.size() + q1.size() + q2.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
